// File: rtl/mult_seq_core.sv
// Sequential shift-add multiplier with start/busy/done handshake.
// One partial-product bit per enabled cycle, followed by one sign-fix cycle.
// In signed mode both operands are reduced to magnitudes at start and the
// product is negated in the final cycle when exactly one operand was negative.
module mult_seq_core #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               neg_flag;

  logic               eff_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_neg;

  // Operand magnitudes, partial-product add (with carry) and negated result
  always_comb begin
    eff_signed = SIGNED_EN & signed_mode;
    a_mag      = (eff_signed && a[WIDTH-1]) ? -a : a;
    b_mag      = (eff_signed && b[WIDTH-1]) ? -b : b;
    sum        = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
    acc_neg    = -acc;
  end

  // Control FSM and datapath registers; everything frozen while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
      neg_flag <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
    end else if (ena) begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand    <= a_mag;
            mplier   <= b_mag;
            neg_flag <= eff_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc      <= '0;
            count    <= '0;
            busy     <= 1'b1;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          // add carry lands in the MSB as the accumulator shifts right
          acc    <= {sum, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          product <= neg_flag ? acc_neg : acc;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_core.sv
// Directed testbench for mult_seq_core (WIDTH=8): a signed-enabled instance
// and a SIGNED_EN=0 instance share clock, reset and enable.
module tb_mult_seq_core;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           ena;
  logic           start, signed_mode;
  logic [W-1:0]   a, b;
  logic           busy, done;
  logic [2*W-1:0] product;

  logic           start_u, signed_mode_u;
  logic [W-1:0]   a_u, b_u;
  logic           busy_u, done_u;
  logic [2*W-1:0] product_u;

  int vectors;
  int miscompares;

  mult_seq_core #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  mult_seq_core #(.WIDTH(W), .SIGNED_EN(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_u),
    .signed_mode(signed_mode_u), .a(a_u), .b(b_u),
    .busy(busy_u), .done(done_u), .product(product_u)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for exactly one edge on the signed instance
  task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic sm);
    a = ia; b = ib; signed_mode = sm; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Ticks until done is seen (bounded); reports ticks taken and busy samples
  task automatic wait_done(output int n, output int bc);
    n = 0; bc = 0;
    while (n < 100) begin
      if (busy) bc++;
      if (done) break;
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b product=%h, want 0 0 0000", busy, done, product);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unsigned_max();
    int n, bc;
    start_op(8'hFF, 8'hFF, 1'b0);
    wait_done(n, bc);
    vectors++;
    if (n !== 9) begin
      miscompares++;
      $display("FAIL unsigned_latency: got %0d edges, want 9", n);
    end
    vectors++;
    if (bc !== 9) begin
      miscompares++;
      $display("FAIL unsigned_busy_len: busy for %0d cycles, want 9", bc);
    end
    vectors++;
    if (product !== 16'hFE01) begin
      miscompares++;
      $display("FAIL unsigned_ff_ff: product=%h, want fe01", product);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || product !== 16'hFE01) begin
      miscompares++;
      $display("FAIL done_one_cycle: done=%b product=%h, want 0 fe01", done, product);
    end
  endtask

  task automatic test_signed();
    logic [W-1:0]   ta [4] = '{8'h80, 8'hFF, 8'h05, 8'hFF};
    logic [W-1:0]   tb [4] = '{8'h80, 8'h01, 8'hFD, 8'h01};
    logic           ts [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [2*W-1:0] te [4] = '{16'h4000, 16'hFFFF, 16'hFFF1, 16'h00FF};
    int n, bc;
    for (int i = 0; i < 4; i++) begin
      start_op(ta[i], tb[i], ts[i]);
      wait_done(n, bc);
      vectors++;
      if (n !== 9 || product !== te[i]) begin
        miscompares++;
        $display("FAIL signed_vec%0d: a=%h b=%h sm=%b product=%h after %0d edges, want %h after 9",
                 i, ta[i], tb[i], ts[i], product, n, te[i]);
      end
      tick();
    end
  endtask

  task automatic test_start_while_busy();
    int n, bc, extra;
    start_op(8'h03, 8'h04, 1'b0);
    tick();
    a = 8'h00; b = 8'h00; signed_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, bc);
    vectors++;
    if (n + 2 !== 9 || product !== 16'h000C) begin
      miscompares++;
      $display("FAIL start_ignored: product=%h after %0d edges, want 000c after 9", product, n + 2);
    end
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) extra++;
    end
    vectors++;
    if (extra !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL no_extra_done: extra done pulses=%0d busy=%b, want 0 0", extra, busy);
    end
  endtask

  task automatic test_stall();
    int n, bc, bad;
    logic [2*W-1:0] held;
    held = product;
    start_op(8'h12, 8'h34, 1'b0);
    repeat (2) tick();
    ena = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy !== 1'b1 || done !== 1'b0 || product !== held) bad++;
    end
    ena = 1'b1;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL stall_frozen: %0d stalled cycles changed outputs, want 0", bad);
    end
    wait_done(n, bc);
    vectors++;
    if (n + 7 !== 14 || product !== 16'h03A8) begin
      miscompares++;
      $display("FAIL stall_latency: product=%h after %0d edges, want 03a8 after 14", product, n + 7);
    end
    // done must hold through a stall
    ena = 1'b0;
    repeat (3) tick();
    vectors++;
    if (done !== 1'b1 || product !== 16'h03A8) begin
      miscompares++;
      $display("FAIL done_hold_stall: done=%b product=%h, want 1 03a8", done, product);
    end
    ena = 1'b1;
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_clear_after_stall: done=%b, want 0", done);
    end
  endtask

  task automatic test_reset_mid_run();
    int n, bc;
    start_op(8'h12, 8'h34, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      miscompares++;
      $display("FAIL async_abort: busy=%b done=%b product=%h, want 0 0 0000", busy, done, product);
    end
    tick();
    rst_n = 1'b1;
    tick();
    start_op(8'h07, 8'h06, 1'b0);
    wait_done(n, bc);
    vectors++;
    if (n !== 9 || product !== 16'h002A) begin
      miscompares++;
      $display("FAIL after_abort: product=%h after %0d edges, want 002a after 9", product, n);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    a_u = 8'hFF; b_u = 8'h02; signed_mode_u = 1'b1; start_u = 1'b1;
    tick();
    start_u = 1'b0;
    n = 0;
    while (!done_u && n < 100) begin tick(); n++; end
    vectors++;
    if (n !== 9 || product_u !== 16'h01FE) begin
      miscompares++;
      $display("FAIL unsigned_build: product=%h after %0d edges, want 01fe after 9", product_u, n);
    end
    // second start presented in the done cycle
    a_u = 8'h03; b_u = 8'h05; start_u = 1'b1;
    tick();
    start_u = 1'b0;
    vectors++;
    if (done_u !== 1'b0 || busy_u !== 1'b1 || product_u !== 16'h01FE) begin
      miscompares++;
      $display("FAIL b2b_accept: done=%b busy=%b product=%h, want 0 1 01fe", done_u, busy_u, product_u);
    end
    n = 1;
    while (!done_u && n < 100) begin tick(); n++; end
    vectors++;
    if (n !== W + 2 || product_u !== 16'h000F) begin
      miscompares++;
      $display("FAIL b2b_spacing: product=%h, done %0d edges after previous, want 000f after %0d",
               product_u, n, W + 2);
    end
    tick();
  endtask

  // start held high continuously on the signed instance
  task automatic test_start_held();
    int n;
    a = 8'hFE; b = 8'h03; signed_mode = 1'b1; start = 1'b1;
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    n = 0;
    tick(); n++;
    while (!done && n < 100) begin tick(); n++; end
    start = 1'b0;
    vectors++;
    if (n !== W + 2 || product !== 16'hFFFA) begin
      miscompares++;
      $display("FAIL start_held: product=%h period=%0d, want fffa period %0d", product, n, W + 2);
    end
    repeat (12) tick();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b1; ena = 1'b1;
    start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    start_u = 1'b0; signed_mode_u = 1'b0; a_u = '0; b_u = '0;
    #2;
    test_reset();
    test_unsigned_max();
    test_signed();
    test_start_while_busy();
    test_stall();
    test_reset_mid_run();
    test_back_to_back();
    test_start_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_seq_core.md
Name: mult_seq_core

Overview:
Parametrised sequential shift-add multiplier. It is the next generation of the team's 4-bit combinational multiplier and is wrapped by the tt_um_* top level, which maps operands and result onto ui_in/uio_in/uo_out.
- Trades area for latency: one partial-product bit per cycle.
- Adds a start/busy/done handshake and an optional two's-complement signed mode.

Parameters:
WIDTH, 8, operand width in bits (legal range 2..16); product is 2*WIDTH bits.
SIGNED_EN, 1, 1 = signed_mode input honoured; 0 = signed_mode ignored, always unsigned.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; when low, all state frozen (stall)
start  input  1  request a multiplication; sampled only in IDLE with ena=1
signed_mode  input  1  1 = operands are two's complement; sampled with start
a  input  WIDTH  multiplicand; sampled with start
b  input  WIDTH  multiplier; sampled with start
busy  output  1  high while a multiplication is in progress (RUN or FIX)
done  output  1  one-cycle pulse when product becomes valid
product  output  2*WIDTH  result register; holds last result until the next done

Behaviour:
- Reset (rst_n low, asynchronous) forces the following, regardless of clk or ena:
  - state=IDLE, busy=0, done=0, product=0.
  - Internal accumulator, operand registers, counter and sign flag cleared.
- States:
  - IDLE: busy=0. On an edge with ena=1 and start=1:
    - capture |a| and |b| (magnitudes when the effective signed flag is set, raw values otherwise);
    - neg_flag = effective signed & (a[MSB] xor b[MSB]);
    - acc=0, count=0; go to RUN.
  - RUN: busy=1. Each enabled edge:
    - if multiplier LSB=1, add multiplicand into upper half of acc;
    - shift acc/multiplier right by one (the add carry enters the MSB);
    - count++.
    - After WIDTH RUN edges (count reaches WIDTH-1 and advances), go to FIX.
  - FIX: busy=1. One enabled edge:
    - product <= neg_flag ? -acc (mod 2^(2*WIDTH)) : acc;
    - done <= 1; go to IDLE.
- Effective signed flag = SIGNED_EN & signed_mode.
- Magnitude of the most negative value -2^(WIDTH-1) is 2^(WIDTH-1), which fits in WIDTH unsigned bits; no overflow is possible, and the signed product always fits in 2*WIDTH bits.
- Latency:
  - start sampled at edge k (ena continuously high) -> done=1 and the new product visible in the cycle after edge k+WIDTH+1.
  - Total WIDTH+1 edges. With WIDTH=8, done asserts 9 edges after the start edge.
- done:
  - Exactly one enabled cycle wide; cleared on the next enabled edge.
  - If ena drops while done=1, done holds until ena returns and an edge occurs.
- Back-to-back: start=1 while done=1 is accepted (state is IDLE). The new operation begins, done clears, and product keeps the old result until the new FIX.
- start while busy=1 is ignored; operand and mode changes during busy have no effect.
- ena=0: no state, counter, accumulator, done or product change; latency is extended by the stalled cycles.
- Reset mid-operation aborts immediately to IDLE with product=0; no done pulse is generated.
- start held high continuously: a new operation starts on every IDLE visit, i.e. every WIDTH+2 edges.

Test Plan:
1. Reset, WIDTH=8, unsigned a=0xFF b=0xFF, start one cycle -> busy high for 9 cycles, done pulses once, product=0xFE01.
2. Signed mode:
   - a=0x80 (-128), b=0x80 -> product=0x4000.
   - a=0xFF (-1), b=0x01 -> product=0xFFFF.
   - a=0x05, b=0xFD (-3) -> product=0xFFF1.
3. start pulsed during busy with a=0x00, b=0x00 -> ignored; first result 0x0C (a=3, b=4) delivered at the normal latency, followed by no extra done.
4. ena dropped for 5 cycles mid-RUN -> done arrives 5 cycles late; product is still correct (a=0x12, b=0x34 -> 0x03A8).
5. Reset asserted 3 cycles into RUN -> busy=0, done=0, product=0 immediately. A subsequent start with a=7, b=6 -> 0x002A.
6. SIGNED_EN=0 build, signed_mode=1, a=0xFF, b=0x02 -> product=0x01FE (unsigned). Back-to-back start on the done cycle -> second done exactly WIDTH+2 edges after the first.
